spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder (slave) for the SPI master controller's bus; sits at the far end of the link, e.g. a board-level loopback peer or FPGA-as-peripheral.
- Oversamples sclk/cs_n/mosi on the system clock, drives miso, and exchanges words with the fabric.
  - TX words arrive on a valid/ready stream.
  - RX words leave on a valid/ready stream.
- Modes 0-3 are set by cpol/cpha inputs; bit order is MSB first.

Parameters:
- DATA_WIDTH, 8, word length in bits (2..32).
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/mosi (>=2).
- TX_IDLE_WORD, '0, word shifted out when the TX buffer is empty (underrun).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cpol_i  in  1  clock idle level; sampled only while cs_n is inactive
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge; sampled only while cs_n is inactive
- spi_sclk_i  in  1  SPI clock (asynchronous)
- spi_cs_n_i  in  1  chip select, active low (asynchronous)
- spi_mosi_i  in  1  master out (asynchronous)
- spi_miso_o  out  1  slave out
- spi_miso_oe_o  out  1  miso output enable (tri-state control)
- tx_data_i  in  DATA_WIDTH  next word to transmit
- tx_valid_i  in  1  tx word valid
- tx_ready_o  out  1  TX holding register empty
- rx_data_o  out  DATA_WIDTH  received word
- rx_valid_o  out  1  rx word valid
- rx_ready_i  in  1  rx word accepted
- frame_end_o  out  1  1-cycle pulse on cs_n deassertion
- tx_underrun_o  out  1  1-cycle pulse: word loaded from TX_IDLE_WORD
- rx_overflow_o  out  1  1-cycle pulse: received word dropped
- frame_err_o  out  1  1-cycle pulse: cs_n rose with a partial word

Behaviour:
- Reset state:
  - all pulse outputs 0; rx_valid_o=0, rx_data_o=0, tx_ready_o=1, spi_miso_o=0, spi_miso_oe_o=0.
  - bit counter=0; FSM=IDLE.
  - Synchronizer flops reset to cs_n=1 and sclk=cpol_i.
- Synchronization and edge detection:
  - sclk, cs_n and mosi each pass SYNC_STAGES flops; edges are detected on the synchronized signals.
  - Leading edge = sclk transition away from cpol; trailing edge = transition back to cpol.
  - Requirement: sclk high and low phases each >= SYNC_STAGES+2 clk_i cycles.
- TX holding register (1 word):
  - tx_ready_o=1 when empty; a transfer occurs when tx_valid_i && tx_ready_o.
  - A load into the shifter empties the holding register in the same cycle. A new handshake may occur in that cycle and keeps the register full.
- FSM IDLE:
  - miso_oe=0; cpol/cpha are latched.
  - On synchronized cs_n fall -> ACTIVE. In that cycle: oe=1, word load, bitcnt=0.
  - CPHA=0: MSB is placed on miso immediately.
  - CPHA=1: miso holds the MSB until the first leading edge, then shifting continues per the edge rules.
- FSM ACTIVE, edge rules:
  - The sample edge (leading if cpha=0, trailing if cpha=1) shifts mosi into rx_shift and increments bitcnt.
  - The shift edge (the other edge) presents the next TX bit on miso. Exception for CPHA=1: the first leading edge of a word presents the MSB of a freshly loaded word.
- Word completion (bitcnt reaches DATA_WIDTH on a sample edge):
  - bitcnt wraps to 0.
  - If rx_valid_o=0 or rx_ready_i=1 in that cycle: rx_data_o <= rx_shift, rx_valid_o <= 1.
  - Otherwise the word is dropped, rx_overflow_o pulses, and the held word is unchanged.
  - The next TX word is loaded at the next shift edge (CPHA=0) or the next leading edge (CPHA=1). A load from an empty buffer uses TX_IDLE_WORD and pulses tx_underrun_o.
- rx_valid_o clears on rx_valid_o && rx_ready_i unless a new word is written in the same cycle.
- cs_n rise (any state of ACTIVE):
  - -> IDLE; oe=0 next cycle; frame_end_o pulses.
  - If bitcnt != 0, frame_err_o pulses and the partial word is discarded.
  - The TX holding register is retained; the shifter is cleared.
- Simultaneous events: a sample edge and a cs_n rise detected in the same cycle -> the edge is ignored and cs_n wins.
- sclk edges seen while in IDLE are ignored. cpol/cpha changes during ACTIVE are ignored until IDLE.
- rst_i during a frame aborts immediately with no pulses. After reset the FSM waits for a cs_n fall; a cs_n already low is not treated as a fall.

Test Plan:
- Mode 0, DATA_WIDTH=8, TX preloaded 0xA5; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1 on sample edges; rx_data_o=0x3C with rx_valid_o=1; frame_end_o pulses once, frame_err_o=0.
- Modes 1, 2, 3 each: TX 0x81, master sends 0x7E -> rx=0x7E and master receives 0x81 in every mode.
- Three-word burst in one frame, TX stream 0x11, 0x22 then empty; master sends 0xAA, 0xBB, 0xCC -> miso words 0x11, 0x22, 0x00; tx_underrun_o pulses once; rx outputs 0xAA, 0xBB, 0xCC.
- rx_ready_i held 0, two words received (0x01, 0x02) -> rx_data_o stays 0x01; rx_overflow_o pulses once at the second completion.
- cs_n raised after 5 bits -> frame_err_o and frame_end_o pulse in the same cycle; no rx_valid; the next frame's word is received correctly.
- rst_i asserted mid-word, then a fresh frame with 0x5A -> all outputs at reset values; rx=0x5A received with no stale bits.

Source files
------------

// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/cs_n/mosi, modes 0-3, MSB first.
// One-word TX holding register in front of the shifter; RX word on valid/ready.
module spi_slave #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  frame_end_o,
    output logic                  tx_underrun_o,
    output logic                  rx_overflow_o,
    output logic                  frame_err_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_vld;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic                   r_cs_armed;

    logic                   r_cpol;
    logic                   r_cpha;
    logic [DATA_WIDTH-1:0]  r_tx_hold;
    logic                   r_tx_full;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic [CW-1:0]          r_bitcnt;
    logic                   r_load_pend;
    logic                   r_miso;
    logic                   r_oe;
    logic                   r_frame_end;
    logic                   r_frame_err;
    logic                   r_underrun;
    logic                   r_overflow;

    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sclk_edge;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_start;
    logic                   w_stop;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_tx_acc;
    logic                   w_word_done;
    logic [CW-1:0]          w_bitcnt_inc;
    logic [DATA_WIDTH-1:0]  w_load_word;
    logic [DATA_WIDTH-1:0]  w_rx_word;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sclk_edge = w_sclk ^ r_sclk_prev;
    assign w_lead      = w_sclk_edge & (w_sclk ^ r_cpol);
    assign w_trail     = w_sclk_edge & ~(w_sclk ^ r_cpol);
    // A fall only counts once a real high level has been seen after reset
    assign w_cs_fall   = r_cs_armed & r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sclk_sync <= {SYNC_STAGES{cpol_i}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= '0;
            r_cs_vld    <= '0;
            r_sclk_prev <= cpol_i;
            r_cs_prev   <= 1'b1;
            r_cs_armed  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_cs_vld    <= {r_cs_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
            r_cs_armed  <= r_cs_armed | (r_cs_vld[SYNC_STAGES-1] & w_cs);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_sample = r_cpha ? w_trail : w_lead;
                    w_shift  = r_cpha ? w_lead : w_trail;
                end
            end
        endcase
    end

    assign w_tx_acc     = tx_valid_i & ~r_tx_full;
    assign w_load       = w_start | (w_shift & r_load_pend);
    assign w_load_word  = r_tx_full ? r_tx_hold : TX_IDLE_WORD;
    assign w_rx_word    = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
    assign w_bitcnt_inc = r_bitcnt + CW'(1);
    assign w_word_done  = w_sample & (w_bitcnt_inc == CW'(DATA_WIDTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpol      <= cpol_i;
            r_cpha      <= cpha_i;
            r_tx_hold   <= '0;
            r_tx_full   <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_bitcnt    <= '0;
            r_load_pend <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_frame_end <= 1'b0;
            r_frame_err <= 1'b0;
            r_underrun  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_end <= 1'b0;
            r_frame_err <= 1'b0;
            r_underrun  <= 1'b0;
            r_overflow  <= 1'b0;

            if (r_state == S_IDLE) begin
                r_cpol <= cpol_i;
                r_cpha <= cpha_i;
            end

            if (w_tx_acc) begin
                r_tx_hold <= tx_data_i;
                r_tx_full <= 1'b1;
            end else if (w_load) begin
                r_tx_full <= 1'b0;
            end
            if (w_load && !r_tx_full) begin
                r_underrun <= 1'b1;
            end

            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end

            if (w_stop) begin
                r_oe        <= 1'b0;
                r_miso      <= 1'b0;
                r_tx_shift  <= '0;
                r_rx_shift  <= '0;
                r_bitcnt    <= '0;
                r_load_pend <= 1'b0;
                r_frame_end <= 1'b1;
                r_frame_err <= (r_bitcnt != '0);
            end else if (w_start) begin
                r_oe        <= 1'b1;
                r_bitcnt    <= '0;
                r_rx_shift  <= '0;
                r_load_pend <= 1'b0;
                r_miso      <= w_load_word[DATA_WIDTH-1];
                // CPHA=1 keeps the MSB in the shifter so the first leading edge re-presents it
                r_tx_shift  <= r_cpha ? w_load_word
                                      : {w_load_word[DATA_WIDTH-2:0], 1'b0};
            end else begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_word;
                    if (w_word_done) begin
                        r_bitcnt    <= '0;
                        r_load_pend <= 1'b1;
                        if (!r_rx_valid || rx_ready_i) begin
                            r_rx_data  <= w_rx_word;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_bitcnt <= w_bitcnt_inc;
                    end
                end
                if (w_shift) begin
                    if (r_load_pend) begin
                        r_load_pend <= 1'b0;
                        r_miso      <= w_load_word[DATA_WIDTH-1];
                        r_tx_shift  <= {w_load_word[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        r_miso      <= r_tx_shift[DATA_WIDTH-1];
                        r_tx_shift  <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso_o    = r_miso;
    assign spi_miso_oe_o = r_oe;
    assign tx_ready_o    = ~r_tx_full;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign frame_end_o   = r_frame_end;
    assign frame_err_o   = r_frame_err;
    assign tx_underrun_o = r_underrun;
    assign rx_overflow_o = r_overflow;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master, pulse counters,
// RX log and hand-computed expected words.
module tb_spi_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_end;
    logic       underrun;
    logic       overflow;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpol_i        (cpol),
        .cpha_i        (cpha),
        .spi_sclk_i    (sclk),
        .spi_cs_n_i    (cs_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .frame_end_o   (frame_end),
        .tx_underrun_o (underrun),
        .rx_overflow_o (overflow),
        .frame_err_o   (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int         fe_n   = 0;
    int         ferr_n = 0;
    int         both_n = 0;
    int         und_n  = 0;
    int         ovf_n  = 0;
    int         rx_n   = 0;
    logic [7:0] rx_log [64];

    always @(negedge clk) begin
        if (frame_end) fe_n <= fe_n + 1;
        if (frame_err) ferr_n <= ferr_n + 1;
        if (frame_end && frame_err) both_n <= both_n + 1;
        if (underrun) und_n <= und_n + 1;
        if (overflow) ovf_n <= ovf_n + 1;
        if (rx_valid && rx_ready) begin
            rx_log[rx_n % 64] <= rx_data;
            rx_n <= rx_n + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        cyc(2 * H);
    endtask

    task automatic tx_push(input logic [7:0] d);
        logic ok;
        ok       = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (tx_ready) begin
                ok = 1'b1;
                cyc(1);
                break;
            end
            cyc(1);
        end
        tx_valid = 1'b0;
        chk("tx_push_ready", 32'(ok), 32'd1);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nb,
                        output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                cyc(H);
                mi[i] = miso;
                sclk  = ~cpol;
                cyc(H);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mo[i];
                cyc(H);
                mi[i] = miso;
                sclk  = cpol;
                cyc(H);
            end
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        cyc(H);
    endtask

    task automatic cs_high();
        cyc(H);
        cs_n = 1'b1;
        cyc(2 * H);
    endtask

    function automatic logic [7:0] rx_last();
        return rx_log[(rx_n - 1) % 64];
    endfunction

    logic [7:0] mi;
    logic [7:0] mi2;
    logic [7:0] mi3;
    int         s_fe;
    int         s_ferr;
    int         s_both;
    int         s_und;
    int         s_ovf;
    int         s_rx;

    initial begin
        rst      = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        cyc(5);

        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_oe", 32'(miso_oe), 32'd0);
        chk("rst_pulses", 32'({frame_end, underrun, overflow, frame_err}),
            32'h0);
        rst = 1'b0;
        cyc(2 * H);

        // mode 0 single word
        s_fe   = fe_n;
        s_ferr = ferr_n;
        tx_push(8'hA5);
        cs_low();
        chk("m0_oe_active", 32'(miso_oe), 32'd1);
        xfer(8'h3C, 8, mi);
        cs_high();
        chk("m0_miso_word", 32'(mi), 32'hA5);
        chk("m0_rx_valid", 32'(rx_valid), 32'd1);
        chk("m0_rx_data", 32'(rx_data), 32'h3C);
        chk("m0_frame_end", 32'(fe_n - s_fe), 32'd1);
        chk("m0_frame_err", 32'(ferr_n - s_ferr), 32'd0);
        chk("m0_oe_idle", 32'(miso_oe), 32'd0);
        rx_ready = 1'b1;
        cyc(1);
        chk("m0_rx_drain", 32'(rx_valid), 32'd0);
        chk("m0_rx_log", 32'(rx_last()), 32'h3C);

        // modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            s_rx = rx_n;
            tx_push(8'h81);
            cs_low();
            xfer(8'h7E, 8, mi);
            cs_high();
            chk($sformatf("mode%0d_miso", m), 32'(mi), 32'h81);
            chk($sformatf("mode%0d_rx_n", m), 32'(rx_n - s_rx), 32'd1);
            chk($sformatf("mode%0d_rx", m), 32'(rx_last()), 32'h7E);
        end

        // three-word burst, mode 1
        set_mode(1'b0, 1'b1);
        s_und = und_n;
        s_rx  = rx_n;
        tx_push(8'h11);
        cs_n = 1'b0;
        cyc(6);
        tx_push(8'h22);
        cyc(H);
        xfer(8'hAA, 8, mi);
        xfer(8'hBB, 8, mi2);
        xfer(8'hCC, 8, mi3);
        cs_high();
        chk("burst_miso0", 32'(mi), 32'h11);
        chk("burst_miso1", 32'(mi2), 32'h22);
        chk("burst_miso2", 32'(mi3), 32'h00);
        chk("burst_underrun", 32'(und_n - s_und), 32'd1);
        chk("burst_rx_n", 32'(rx_n - s_rx), 32'd3);
        chk("burst_rx0", 32'(rx_log[s_rx % 64]), 32'hAA);
        chk("burst_rx1", 32'(rx_log[(s_rx + 1) % 64]), 32'hBB);
        chk("burst_rx2", 32'(rx_log[(s_rx + 2) % 64]), 32'hCC);

        // overflow with rx_ready held low, mode 0
        set_mode(1'b0, 1'b0);
        rx_ready = 1'b0;
        s_ovf    = ovf_n;
        cs_low();
        xfer(8'h01, 8, mi);
        xfer(8'h02, 8, mi);
        cs_high();
        chk("ovf_rx_valid", 32'(rx_valid), 32'd1);
        chk("ovf_rx_data", 32'(rx_data), 32'h01);
        chk("ovf_pulses", 32'(ovf_n - s_ovf), 32'd1);
        rx_ready = 1'b1;
        cyc(2);

        // partial word then a clean frame
        s_fe   = fe_n;
        s_ferr = ferr_n;
        s_both = both_n;
        s_rx   = rx_n;
        cs_low();
        xfer(8'hFF, 5, mi);
        cs_high();
        chk("ferr_err", 32'(ferr_n - s_ferr), 32'd1);
        chk("ferr_end", 32'(fe_n - s_fe), 32'd1);
        chk("ferr_same_cycle", 32'(both_n - s_both), 32'd1);
        chk("ferr_no_rx", 32'(rx_n - s_rx), 32'd0);
        cs_low();
        xfer(8'hC3, 8, mi);
        cs_high();
        chk("ferr_next_rx", 32'(rx_last()), 32'hC3);

        // reset mid-word with cs_n still low
        s_fe = fe_n;
        cs_low();
        xfer(8'hE7, 3, mi);
        rst = 1'b1;
        cyc(3);
        chk("mrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("mrst_rx_data", 32'(rx_data), 32'h0);
        chk("mrst_tx_ready", 32'(tx_ready), 32'd1);
        chk("mrst_miso", 32'(miso), 32'd0);
        chk("mrst_oe", 32'(miso_oe), 32'd0);
        rst = 1'b0;
        cyc(3 * H);
        chk("mrst_no_fall", 32'(miso_oe), 32'd0);
        cs_n = 1'b1;
        cyc(2 * H);
        chk("mrst_no_pulse", 32'(fe_n - s_fe), 32'd0);
        s_rx = rx_n;
        cs_low();
        xfer(8'h5A, 8, mi);
        cs_high();
        chk("mrst_rx_n", 32'(rx_n - s_rx), 32'd1);
        chk("mrst_rx", 32'(rx_last()), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
